// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: hunts an N-bit sync word in the LSB-first bit stream, then packs FRAME_WORDS data words.
// Latency: a word is on dout one cycle after the edge sampling its last bit (the parity bit when DESER_PARITY_EN is defined).
// Backpressure: one-entry output register; a word completing while dout is held unconsumed is dropped and overrun pulses.
module serial_frame_deser #(
  parameter int             N           = 8,
  parameter logic [N-1:0]   SYNC        = 8'hA5,
  parameter int             FRAME_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_in,
  input  logic         s_valid,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         locked,
  output logic         overrun,
  output logic         parity_err
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(N + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);

  localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(N);
  localparam logic [WW-1:0] WORDS_LAST = WW'(FRAME_WORDS);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1
`ifdef DESER_PARITY_EN
    , S_PAR = 2'd2
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   win_q, win_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]  word_cnt_q, word_cnt_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           dout_valid_q, dout_valid_d;
  logic           overrun_q, overrun_d;
  logic           parity_err_q, parity_err_d;

  logic [N-1:0]   win_next;
  logic [FW-1:0]  fill_next;
  logic [N-1:0]   word_dat;
  logic           word_end;   // a word slot of the frame is finished (good or bad)
  logic           word_bad;   // finished word failed its parity check

  // Frame FSM: sync hunt, bit/word counting and window shifting on accepted bits.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    word_end   = 1'b0;
    word_bad   = 1'b0;
    word_dat   = win_q;
    win_next   = {s_in, win_q[N-1:1]};
    fill_next  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);

    if (s_valid) begin
      case (state_q)
        S_HUNT: begin
          win_d  = win_next;
          fill_d = fill_next;
          // fill guards against matching on bits left over from before reset or the last frame
          if (fill_next == FILL_FULL && win_next == SYNC) begin
            state_d    = S_DATA;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
        S_DATA: begin
          win_d    = win_next;
          word_dat = win_next;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef DESER_PARITY_EN
            state_d   = S_PAR;
`else
            word_end  = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
`ifdef DESER_PARITY_EN
        S_PAR: begin
          // window is frozen so it still holds the data word; even parity over word + parity bit
          word_end = 1'b1;
          word_bad = ^{win_q, s_in};
        end
`endif
        default: begin
          state_d = S_HUNT;
          fill_d  = '0;
        end
      endcase
    end

    // dropped and errored words still consume a slot of the frame
    if (word_end) begin
      word_cnt_d = word_cnt_q + WW'(1);
      if (word_cnt_d == WORDS_LAST) begin
        state_d = S_HUNT;
        fill_d  = '0;
      end else begin
        state_d = S_DATA;
      end
    end
  end

  // Output register: load on completion when free or being drained, otherwise drop and flag.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    parity_err_d = word_end && word_bad;
    if (word_end && !word_bad) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = word_dat;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d    = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously so a partial word is never presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HUNT;
      win_q        <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = (state_q != S_HUNT);
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Bench for serial_frame_deser: directed scenarios plus randomized frames,
// checked every cycle against a bit-list reference model of the frame rules.
module tb_serial_frame_deser;

  localparam int          N    = 8;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int          FWS  = 4;
`ifdef DESER_PARITY_EN
  localparam int          PB   = 1;
`else
  localparam int          PB   = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_in, s_valid, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, locked, overrun, parity_err;

  always #5 clk = ~clk;

  serial_frame_deser #(.N(N), .SYNC(SYNC), .FRAME_WORDS(FWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_in       (s_in),
    .s_valid    (s_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .locked     (locked),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  bit         m_hunt;
  bit         hist[$];    // bits seen since hunting restarted, newest at back
  bit         wbits[$];   // bits of the word being received
  int         m_words;
  logic [7:0] m_dout;
  bit         m_vld, m_ovr, m_perr;

  function automatic void model_reset();
    m_hunt = 1; hist.delete(); wbits.delete(); m_words = 0;
    m_dout = '0; m_vld = 0; m_ovr = 0; m_perr = 0;
  endfunction

  function automatic void model_step(input bit sv, input bit sin, input bit rdy);
    bit         done = 0;
    bit         good = 0;
    int         val  = 0;
    int         par  = 0;
    logic [7:0] word = '0;
    if (sv) begin
      if (m_hunt) begin
        hist.push_back(sin);
        if (hist.size() > N) void'(hist.pop_front());
        if (hist.size() == N) begin
          foreach (hist[i]) val += int'(hist[i]) << i;
          if (val == int'(SYNC)) begin
            m_hunt = 0; wbits.delete(); m_words = 0;
          end
        end
      end else begin
        wbits.push_back(sin);
        if (wbits.size() == N + PB) begin
          for (int i = 0; i < N; i++) word[i] = wbits[i];
          foreach (wbits[i]) par ^= int'(wbits[i]);
          done = 1;
          good = (PB == 0) || (par == 0);
          wbits.delete();
          m_words++;
          if (m_words == FWS) begin
            m_hunt = 1; hist.delete();
          end
        end
      end
    end
    m_perr = done && !good;
    m_ovr  = 0;
    if (done && good) begin
      if (!m_vld || rdy) begin m_dout = word; m_vld = 1; end
      else m_ovr = 1;
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  int         ovr_seen, perr_seen, lock_seen, vld_cyc;
  logic [7:0] got_q[$];
  bit         gap_en;
  int         rdy_mode;   // 0: always ready, 1: never ready, 2: random

  function automatic bit cur_rdy();
    if (rdy_mode == 0) return 1'b1;
    if (rdy_mode == 1) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input bit sv, input bit sin, input bit rdy);
    s_valid = sv; s_in = sin; dout_ready = rdy;
    if (dout_valid && rdy) got_q.push_back(dout);
    @(posedge clk);
    model_step(sv, sin, rdy);
    @(negedge clk);
    chk("dout_valid", dout_valid, m_vld);
    chk("locked", locked, !m_hunt);
    chk("overrun", overrun, m_ovr);
    chk("parity_err", parity_err, m_perr);
    if (m_vld) chk("dout", dout, m_dout);
    if (overrun)    ovr_seen++;
    if (parity_err) perr_seen++;
    if (locked)     lock_seen++;
    if (dout_valid) vld_cyc++;
  endtask

  task automatic send_bit(input bit b);
    if (gap_en) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), cur_rdy());
    step(1'b1, b, cur_rdy());
  endtask

  task automatic send_raw(input logic [7:0] w);
    for (int i = 0; i < N; i++) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [7:0] w);
    send_raw(w);
    if (PB != 0) send_bit(^w);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, cur_rdy());
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 1'b0; s_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_dout", dout, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_parity_err", parity_err, 0);
    model_reset();
    ovr_seen = 0; perr_seen = 0; lock_seen = 0; vld_cyc = 0; got_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] exp_words[4];
  logic [7:0] w;
  bit         b;

  initial begin
    exp_words[0] = 8'h3C; exp_words[1] = 8'h81; exp_words[2] = 8'hFF; exp_words[3] = 8'h00;
    rst_n = 1'b1; s_in = 1'b0; s_valid = 1'b0; dout_ready = 1'b0;
    gap_en = 0; rdy_mode = 0;
    model_reset();
    do_reset();

    // Reset in the middle of a frame with a held word, then a sync tail must not lock.
    rdy_mode = 1;
    send_raw(SYNC);
    send_word(8'h55);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    do_reset();
    rdy_mode = 0;
    for (int i = 1; i < N; i++) send_bit(SYNC[i]);
    chk("tail_no_lock", lock_seen, 0);
    chk("tail_no_valid", vld_cyc, 0);

    // Lock and pack one frame.
    do_reset();
    send_raw(SYNC);
    chk("locked_after_sync", locked, 1);
    foreach (exp_words[i]) send_word(exp_words[i]);
    idle(3);
    chk("frame_word_count", got_q.size(), 4);
    foreach (exp_words[i]) if (i < got_q.size()) chk("frame_word", got_q[i], exp_words[i]);
    chk("unlocked_after_frame", locked, 0);

    // False sync: A4 followed by bits that never form A5.
    do_reset();
    send_raw(8'hA4);
    w = 8'hA4;
    for (int i = 0; i < 64; i++) begin
      b = 1'($urandom_range(0, 1));
      if ({b, w[7:1]} == SYNC) b = ~b;
      w = {b, w[7:1]};
      send_bit(b);
    end
    chk("false_sync_lock", lock_seen, 0);
    chk("false_sync_valid", vld_cyc, 0);

    // Overrun, then drain coinciding with a completion.
    do_reset();
    rdy_mode = 1;
    send_raw(SYNC);
    send_word(8'h11);
    send_word(8'h22);
    chk("ovr_held_dout", dout, 8'h11);
    chk("ovr_count", ovr_seen, 1);
    w = 8'h33;
    for (int i = 0; i < N + PB; i++) begin
      if (i == N + PB - 1) rdy_mode = 0;
      send_bit((i < N) ? w[i] : ^w);
    end
    chk("replace_dout", dout, 8'h33);
    chk("replace_valid", dout_valid, 1);
    chk("replace_no_ovr", ovr_seen, 1);
    send_word(8'h44);
    idle(2);
    chk("ovr_frame_unlocked", locked, 0);

    // Same frame with random stalls between bits.
    do_reset();
    gap_en = 1;
    send_raw(SYNC);
    foreach (exp_words[i]) send_word(exp_words[i]);
    idle(3);
    chk("gap_word_count", got_q.size(), 4);
    foreach (exp_words[i]) if (i < got_q.size()) chk("gap_word", got_q[i], exp_words[i]);

    // Random frames with noise, stalls and random backpressure.
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 10)) send_bit(1'($urandom_range(0, 1)));
      send_raw(SYNC);
      for (int k = 0; k < FWS; k++) send_word(8'($urandom));
    end
    rdy_mode = 0;
    idle(4);
    gap_en = 0;

`ifdef DESER_PARITY_EN
    // Good parity word delivered, bad parity word dropped but counted.
    do_reset();
    send_raw(SYNC);
    send_raw(8'h03); send_bit(1'b0);
    send_raw(8'h07); send_bit(1'b0);
    chk("par_err_count", perr_seen, 1);
    send_word(8'h5A);
    send_word(8'h0F);
    idle(2);
    chk("par_word_count", got_q.size(), 3);
    if (got_q.size() > 0) chk("par_first_word", got_q[0], 8'h03);
    chk("par_unlocked", locked, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_frame_deser.md
# serial_frame_deser

Downstream consumer of the free-running serial shift stage. Takes its LSB-first serial bit output, hunts for a fixed sync word in a sliding window, and, once locked, packs a fixed number of N-bit data words. Completed words are presented on a one-entry valid/ready output register. The block then drops back to hunting for the next frame.

## Interface

Parameters:

- N, 8: word width in bits (≥ 2).
- SYNC, 8'hA5: N-bit sync pattern, compared as a word, LSB received first.
- FRAME_WORDS, 4: data words per frame (≥ 1).

Ports:

- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- s_in, input, 1: serial bit, LSB-first, from the upstream shift stage's s_out.
- s_valid, input, 1: bit strobe; s_in is sampled only when s_valid=1.
- dout, output, N: assembled data word.
- dout_valid, output, 1: dout holds an unconsumed word.
- dout_ready, input, 1: consumer accepts dout when dout_valid && dout_ready.
- locked, output, 1: 1 while in DATA state.
- overrun, output, 1: one-cycle pulse, completed word dropped.
- parity_err, output, 1: one-cycle pulse, parity mismatch (0 when parity is compiled out).

## Operation

- Shift window win[N-1:0]: on each s_valid, win <= {s_in, win[N-1:1]}. The newest bit enters at the MSB, so after N bits win equals the transmitted word.
- fill counter: saturates at N and is cleared on entry to HUNT, so a sync cannot match on stale or partial window contents.
- States:
  - HUNT: on each s_valid, evaluate the next window value. If fill reaches N and next win == SYNC, go to DATA and clear bit_cnt and word_cnt.
  - DATA: bit_cnt counts s_valid bits 0..N-1. On the Nth bit the word is complete: word_cnt increments and bit_cnt wraps to 0. When word_cnt reaches FRAME_WORDS, go to HUNT on the same edge.
  - PAR (parity build only): after the Nth data bit, one extra bit is consumed before the word is delivered.
- Output register:
  - Word completes while output empty, or while dout_ready=1: load dout, dout_valid=1.
  - Word completes while dout_valid=1 and dout_ready=0: keep the old word, drop the new one, pulse overrun. The frame still advances word_cnt.
  - Handshake with no completion: dout_valid goes to 0 next edge.
- A dropped or errored word still counts toward FRAME_WORDS.

## Timing

- Reset values: state=HUNT, win=0, fill=0, bit_cnt=0, word_cnt=0, dout=0, dout_valid=0, locked=0, overrun=0, parity_err=0.
- Latency: dout and dout_valid are valid the cycle after the edge that samples the last bit of a word (last data bit, or the parity bit in the parity build).
- locked rises the cycle after the edge that samples the final sync bit. It falls the cycle after the edge that completes the FRAME_WORDS-th word.
- s_valid=0: no state, counter or window change; the output handshake still operates.
- Completion and handshake on the same edge: the new word replaces the old, dout_valid stays 1, no overrun.
- rst_n low mid-frame: all state is cleared immediately and asynchronously. A partial word is discarded and never presented.
- Back-to-back frames: sync detection restarts from fill=0 at the HUNT entry edge. At least N further bits are needed to relock.

## Configuration

- DESER_PARITY_EN defined:
  - Each data word is followed by one even-parity bit (XOR of the word and the parity bit must be 0).
  - On mismatch, parity_err pulses for one cycle and the word is dropped (not loaded to dout).
  - Adds 1 bit of latency per word.
- DESER_PARITY_EN undefined:
  - No PAR state.
  - parity_err is tied 0.
  - Words are delivered directly after N data bits.

## Test plan

- Reset: hold rst_n=0 mid-stream, then release → all outputs 0, locked=0, no dout_valid for the following 7 bits even if they match a sync tail.
- Lock and packing (N=8, SYNC=A5, FRAME_WORDS=4): send 1,0,1,0,0,1,0,1, then words 0x3C, 0x81, 0xFF, 0x00 LSB-first with dout_ready=1 → locked=1, dout sequence 3C, 81, FF, 00 with one dout_valid each, then locked=0.
- False sync: send 0xA4 and then random non-A5 bits for 64 bits → locked stays 0, no dout_valid.
- Overrun: with dout_ready=0, lock and send 0x11, 0x22 → dout=0x11 held, overrun pulses once at 0x22 completion. Then assert dout_ready with a simultaneous third-word completion → dout=0x33, no overrun.
- s_valid gaps: insert random s_valid=0 stalls between bits of a frame → identical dout sequence to the gap-free run.
- DESER_PARITY_EN: send word 0x03 with parity 0 → dout=0x03. Send word 0x07 with parity 0 → parity_err pulse, no dout_valid, word_cnt still advances.
